// File: rtl/i2c_addr_pkg.sv
// i2c_addr_pkg: shared types and constants for the I2C address matcher.
package i2c_addr_pkg;
    typedef enum logic [2:0] {IDLE, BYTE1, ACK1, BYTE2, ACK2, DONE} addr_state_t;
    localparam logic [7:0] GC_ADDR        = 8'h00;
    localparam logic [4:0] TEN_BIT_PREFIX = 5'b11110;
    localparam logic [3:0] ACK_BITS       = 4'd8;
endpackage

// File: rtl/i2c_scl_sda_sync.sv
// i2c_scl_sda_sync: synchronises SCL/SDA into the system clock and emits
// registered single-cycle SCL edge pulses.
module i2c_scl_sda_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o
);
    logic [SYNC_STAGES-1:0] scl_q, sda_q;
    logic scl_prev_q, rise_q, fall_q;
    // Synchronisers reset to the idle-high bus level so release causes no spurious edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            scl_q      <= '1;
            sda_q      <= '1;
            scl_prev_q <= 1'b1;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            scl_q      <= {scl_q[SYNC_STAGES-2:0], scl_i};
            sda_q      <= {sda_q[SYNC_STAGES-2:0], sda_i};
            scl_prev_q <= scl_q[SYNC_STAGES-1];
            rise_q     <= scl_q[SYNC_STAGES-1] & ~scl_prev_q;
            fall_q     <= ~scl_q[SYNC_STAGES-1] & scl_prev_q;
        end
    end
    assign sda_o      = sda_q[SYNC_STAGES-1];
    assign scl_rise_o = rise_q;
    assign scl_fall_o = fall_q;
endmodule

// File: rtl/i2c_addr_matcher.sv
// i2c_addr_matcher: decodes the I2C address phase against programmable 7/10-bit
// entries plus general call, and drives the ACK pull-down.
module i2c_addr_matcher
    import i2c_addr_pkg::*;
#(
    parameter int NUM_ADDR    = 2,
    parameter bit GC_EN       = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                                        FPGA_clk,
    input  logic                                        rst,
    input  logic                                        SCL,
    input  logic                                        SDA,
    input  logic                                        enable,
    input  logic                                        stop,
    input  logic [NUM_ADDR*10-1:0]                      own_addr,
    input  logic [NUM_ADDR-1:0]                         addr_mode,
    output logic                                        done,
    output logic                                        selected,
    output logic [$clog2(NUM_ADDR > 1 ? NUM_ADDR : 2)-1:0] match_idx,
    output logic                                        rw,
    output logic                                        general_call,
    output logic                                        sda_ack_drive
);
    localparam int IW = $clog2(NUM_ADDR > 1 ? NUM_ADDR : 2);
    addr_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] sh_q, sh_d;
    logic ack_q, ack_d, done_q, done_d, sel_q, sel_d, rw_q, rw_d, gc_q, gc_d;
    logic crw_q, crw_d, cgc_q, cgc_d, cten_q, cten_d, armed_q, armed_d;
    logic [IW-1:0] idx_q, idx_d, cidx_q, cidx_d, aidx_q, aidx_d, hit_idx;
    logic hit, hit_gc, hit7, hit_ten, sda_s, scl_rise, scl_fall;
    logic [9:0] ent [NUM_ADDR];

    i2c_scl_sda_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i(FPGA_clk), .rst_ni(rst), .scl_i(SCL), .sda_i(SDA),
        .sda_o(sda_s), .scl_rise_o(scl_rise), .scl_fall_o(scl_fall)
    );

    // Descending scan so the lowest matching index wins; 0x01 is reserved and never matches.
    always_comb begin
        hit = 1'b0;
        hit_gc = 1'b0;
        hit7 = 1'b0;
        hit_ten = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < NUM_ADDR; i++) ent[i] = own_addr[10*i +: 10];
        if (GC_EN && sh_q == GC_ADDR) begin
            hit = 1'b1;
            hit_gc = 1'b1;
        end else if (sh_q[7:1] != 7'd0) begin
            for (int i = NUM_ADDR-1; i >= 0; i--) begin
                if (!addr_mode[i] && sh_q[7:1] == ent[i][6:0]) begin
                    hit = 1'b1;
                    hit7 = 1'b1;
                    hit_ten = 1'b0;
                    hit_idx = IW'(i);
                end else if (addr_mode[i] && sh_q[7:3] == TEN_BIT_PREFIX && sh_q[2:1] == ent[i][9:8]
                             && (!sh_q[0] || (armed_q && aidx_q == IW'(i)))) begin
                    hit = 1'b1;
                    hit7 = 1'b0;
                    hit_ten = !sh_q[0];
                    hit_idx = IW'(i);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        sh_d = sh_q;
        ack_d = ack_q;
        done_d = 1'b0;
        sel_d = sel_q;
        idx_d = idx_q;
        rw_d = rw_q;
        gc_d = gc_q;
        cidx_d = cidx_q;
        crw_d = crw_q;
        cgc_d = cgc_q;
        cten_d = cten_q;
        armed_d = armed_q;
        aidx_d = aidx_q;
        if (stop) begin
            state_d = IDLE;
            ack_d = 1'b0;
            armed_d = 1'b0;
            sel_d = 1'b0;
        end else if (enable) begin
            state_d = BYTE1;
            cnt_d = '0;
            ack_d = 1'b0;
            sel_d = 1'b0;
            gc_d = 1'b0;
            idx_d = '0;
            rw_d = 1'b0;
        end else begin
            case (state_q)
                BYTE1, BYTE2: begin
                    if (cnt_q != ACK_BITS) begin
                        if (scl_rise) begin
                            sh_d = {sh_q[6:0], sda_s};
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (state_q == BYTE1) begin
                        state_d = hit ? ACK1 : IDLE;
                        done_d = !hit;
                        cidx_d = hit_idx;
                        crw_d = sh_q[0];
                        cgc_d = hit_gc;
                        cten_d = hit_ten;
                        if (hit_gc || hit7) armed_d = 1'b0;
                    end else if (sh_q == ent[cidx_q][7:0]) begin
                        state_d = ACK2;
                        armed_d = 1'b1;
                        aidx_d = cidx_q;
                    end else begin
                        state_d = IDLE;
                        done_d = 1'b1;
                        armed_d = 1'b0;
                    end
                end
                ACK1, ACK2: begin
                    // First fall raises the pull-down, the next one (after the 9th rise) releases it.
                    if (scl_fall && !ack_q) ack_d = 1'b1;
                    else if (scl_fall) begin
                        ack_d = 1'b0;
                        cnt_d = '0;
                        if (state_q == ACK1 && cten_q) state_d = BYTE2;
                        else begin
                            state_d = DONE;
                            done_d = 1'b1;
                            sel_d = 1'b1;
                            idx_d = cidx_q;
                            rw_d = crw_q;
                            gc_d = cgc_q;
                        end
                    end
                end
                DONE: state_d = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge FPGA_clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            sh_q <= '0;
            ack_q <= 1'b0;
            done_q <= 1'b0;
            sel_q <= 1'b0;
            idx_q <= '0;
            rw_q <= 1'b0;
            gc_q <= 1'b0;
            cidx_q <= '0;
            crw_q <= 1'b0;
            cgc_q <= 1'b0;
            cten_q <= 1'b0;
            armed_q <= 1'b0;
            aidx_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            sh_q <= sh_d;
            ack_q <= ack_d;
            done_q <= done_d;
            sel_q <= sel_d;
            idx_q <= idx_d;
            rw_q <= rw_d;
            gc_q <= gc_d;
            cidx_q <= cidx_d;
            crw_q <= crw_d;
            cgc_q <= cgc_d;
            cten_q <= cten_d;
            armed_q <= armed_d;
            aidx_q <= aidx_d;
        end
    end

    assign done = done_q;
    assign selected = sel_q;
    assign match_idx = idx_q;
    assign rw = rw_q;
    assign general_call = gc_q;
    assign sda_ack_drive = ack_q;
endmodule

// File: doc/i2c_addr_matcher.md
Name: i2c_addr_matcher

Overview:
Parametrised successor to the I2C slave address decoder. It decodes the address phase after each START or repeated START and matches against NUM_ADDR programmable entries, each either 7-bit or 10-bit. It also detects the general call address, captures the R/W bit, and drives the ACK low-pulse on SDA. It runs in the FPGA_clk domain, synchronises SCL/SDA internally, and sits between the start/stop detector and the slave byte engine.

Parameters:
NUM_ADDR, 2, number of own-address entries (1..8).
GC_EN, 1, 1 = ACK the general call (0x00 + write).
SYNC_STAGES, 2, flip-flop stages on the SCL and SDA synchronisers (>=2).

Ports:
FPGA_clk  input  1  system clock; must run at least 8x faster than SCL.
rst  input  1  asynchronous, active-low reset.
SCL  input  1  raw bus clock, asynchronous.
SDA  input  1  raw bus data, asynchronous.
enable  input  1  one-cycle pulse from the start detector on every START or repeated START.
stop  input  1  one-cycle pulse on STOP; aborts decoding and disarms the 10-bit state.
own_addr  input  NUM_ADDR*10  entry i sits at bits [10i+9:10i]; 7-bit entries use bits [6:0].
addr_mode  input  NUM_ADDR  bit i set = entry i is a 10-bit address.
done  output  1  one-cycle pulse when the address phase completes, matched or not.
selected  output  1  this slave is addressed.
match_idx  output  $clog2(NUM_ADDR) (min 1)  index of the matched entry.
rw  output  1  captured R/W bit (1 = read).
general_call  output  1  matched the general call address.
sda_ack_drive  output  1  1 = pull SDA low; drives the external open-drain buffer.

Behaviour:
- Reset (rst low, async): state IDLE; all outputs 0; bit counter, shift register and ten_armed/armed_idx cleared.
- Edge detection on the synchronised SCL:
  - scl_rise = sync high & previous low; scl_fall is the reverse.
  - Each edge is exactly one FPGA_clk pulse.
  - SDA is sampled from the synchroniser output on scl_rise.
- FSM states: IDLE, BYTE1, ACK1, BYTE2, ACK2, DONE.
- IDLE: enable -> BYTE1. Clear selected, general_call, match_idx, rw and the bit counter.
- BYTE1: shift SDA in MSB first on each scl_rise. In the cycle after the 8th sample, decide using the first match below:
  - GC_EN and byte == 0x00 -> general_call=1.
  - byte == 0x01 is never a general call.
  - 7-bit entry i with byte[7:1] == own_addr[i][6:0] -> match.
  - byte[7:3] == 5'b11110 and 10-bit entry i with byte[2:1] == own_addr[i][9:8]:
    - rw=0 -> candidate; continue to BYTE2.
    - rw=1 -> match only if ten_armed and armed_idx == i.
  - Priority: general call, then the lowest matching index.
  - No match -> done pulse, selected=0, go to IDLE. SDA is never driven.
- ACK1 / ACK2:
  - Raise sda_ack_drive on the first scl_fall after the 8th rise.
  - Hold it through the 9th rise; release it on the following scl_fall.
  - ACK1 then goes to BYTE2 for a 10-bit write candidate, otherwise to DONE.
  - ACK2 always goes to DONE.
- BYTE2: receive 8 bits and compare with own_addr[idx][7:0].
  - Match -> ACK2; set ten_armed=1 and armed_idx=idx.
  - Mismatch -> done pulse, selected=0, ten_armed=0, go to IDLE.
- DONE:
  - One cycle: done=1; selected, rw, match_idx and general_call are set.
  - These outputs hold until the next enable, stop or reset. Then go to IDLE.
- Latency: done is high in the FPGA_clk cycle after the decision event:
  - the releasing scl_fall of the final ACK, or
  - the evaluation cycle on a mismatch.
- enable in any state other than IDLE is a repeated START:
  - go to BYTE1, clear the counter, release sda_ack_drive on the next cycle;
  - clear selected, general_call, match_idx and rw;
  - ten_armed is kept.
- stop in any state: go to IDLE on the next cycle; clear sda_ack_drive, ten_armed and selected; no done pulse.
- If enable and stop arrive in the same cycle, stop wins.
- A 7-bit match or general call clears ten_armed.

Decomposition:
- Package i2c_addr_pkg:
  - state enum addr_state_t;
  - constants GC_ADDR = 8'h00, TEN_BIT_PREFIX = 5'b11110, ACK_BITS = 8.
- Sub-module i2c_scl_sda_sync: SYNC_STAGES synchroniser for SCL and SDA, plus registered scl_rise/scl_fall pulses. Reusable by the byte engine.

Test Plan:
Common setup: NUM_ADDR=2; entry0 = 7-bit 0x08; entry1 = 10-bit 0x2A5 (addr_mode=2'b10); SCL period 20 FPGA_clk cycles.
1. enable, byte 0x12 (0x09 write) -> done pulse; selected=0; sda_ack_drive never 1.
2. enable, byte 0x11 (0x08 read) -> sda_ack_drive high across the 9th SCL high; done pulse after the release fall; selected=1, match_idx=0, rw=1.
3. enable, bytes 0xF4 then 0xA5 -> two ACK pulses; selected=1, match_idx=1, rw=0.
4. Continue from 3: enable (repeated START), byte 0xF5 -> one ACK; done after ACK1; selected=1, match_idx=1, rw=1. Repeat after a stop instead -> no ACK, selected=0.
5. GC_EN=1: byte 0x00 -> ACK, general_call=1, selected=1. Byte 0x01 -> no ACK, general_call=0.
6. Abort cases, each during scenario 2:
   - rst low in the middle of bit 5 -> all outputs 0 immediately.
   - stop during ACK1 -> sda_ack_drive=0 next cycle, no done.
   - enable during bit 4 -> restart and correct decode of the new byte.
